// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: word width, opcode field values
// and the fetch-unit state encoding.
package cpu16_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_LOGIC = 4'b0000;
    localparam logic [3:0] OP_ARITH = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SLTI  = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BEQ   = 4'b1111;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter register with its next-PC selection: hold, step, redirect, reset.
// Also exposes PC+PCStep so the fetch unit can latch it without a second adder.
module program_counter
    import cpu16_pkg::*;
#(
    parameter int                   DataWidth   = WORD_W,
    parameter logic [DataWidth-1:0] ResetVector = '0,
    parameter int                   PCStep      = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 i_advance,
    input  logic                 i_redirect,
    input  logic [DataWidth-1:0] i_target,
    output logic [DataWidth-1:0] o_pc,
    output logic [DataWidth-1:0] o_pc_inc
);

    logic [DataWidth-1:0] r_pc;
    logic [DataWidth-1:0] w_pc_next;
    logic [DataWidth-1:0] w_pc_inc;

    // Wraps modulo 2^DataWidth by truncation.
    assign w_pc_inc = r_pc + DataWidth'(PCStep);

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = {i_target[DataWidth-1:1], 1'b0};
        end else if (i_advance) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc <= ResetVector;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_inc = w_pc_inc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instruction words over a req/ack handshake and presents
// them with their opcode and PC+2 to decode; honours stall and branch redirect.
module instruction_fetch_unit
    import cpu16_pkg::*;
#(
    parameter int                   DataWidth   = WORD_W,
    parameter logic [DataWidth-1:0] ResetVector = '0,
    parameter int                   PCStep      = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    output logic                 IMemReq,
    output logic [DataWidth-1:0] IMemAddr,
    input  logic                 IMemAck,
    input  logic [DataWidth-1:0] IMemData,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [DataWidth-1:0] BranchTarget,
    output logic [DataWidth-1:0] Instruction,
    output logic [3:0]           OPCode,
    output logic [DataWidth-1:0] PCPlus2,
    output logic                 InstrValid
);

    fetch_state_e         r_state;
    fetch_state_e         w_state_next;
    logic [DataWidth-1:0] r_instr;
    logic [DataWidth-1:0] r_pcplus2;
    logic [DataWidth-1:0] w_pc;
    logic [DataWidth-1:0] w_pc_inc;
    logic                 w_load;
    logic                 w_advance;
    logic                 w_req;
    logic                 w_valid;

    program_counter #(
        .DataWidth   (DataWidth),
        .ResetVector (ResetVector),
        .PCStep      (PCStep)
    ) u_pc (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_advance  (w_advance),
        .i_redirect (BranchTaken),
        .i_target   (BranchTarget),
        .o_pc       (w_pc),
        .o_pc_inc   (w_pc_inc)
    );

    // A redirect wins over both a same-cycle Ack and Stall.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            FETCH: begin
                w_req = !Reset;
                if (!BranchTaken && IMemAck) begin
                    w_load       = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_valid = 1'b1;
                if (!BranchTaken && !Stall) begin
                    w_advance    = 1'b1;
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
        if (BranchTaken) begin
            w_state_next = FETCH;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= FETCH;
            r_instr   <= '0;
            r_pcplus2 <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_instr   <= IMemData;
                r_pcplus2 <= w_pc_inc;
            end
        end
    end

    assign IMemReq     = w_req;
    assign IMemAddr    = w_pc;
    assign Instruction = r_instr;
    assign OPCode      = r_instr[DataWidth-1 -: 4];
    assign PCPlus2     = r_pcplus2;
    assign InstrValid  = w_valid;

endmodule
